// File: rtl/if_fetch_unit.sv
// IF-stage fetch front-end: PC owner, synchronous imem request, prefetch FIFO to decode.
// Optional IF_FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc_p0;
    logic             vld_p1;
    logic [31:0]      inflight_pc_p1;
    logic [31:0]      pc_q    [FIFO_DEPTH];
    logic [31:0]      instr_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             pop;
    logic             push;
    logic             issue;
    logic [CNT_W:0]   occ;

    assign pop  = (count != '0) && id_ready;
    assign push = vld_p1 && !redirect_valid;
    // Occupancy after this edge, counting the request whose data is still in memory.
    assign occ   = {1'b0, count} + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);
    assign issue = !redirect_valid && (occ < (CNT_W+1)'(FIFO_DEPTH));

    assign imem_addr = fetch_pc_p0;
    assign id_valid  = (count != '0);
    assign id_pc     = pc_q[rd_ptr];
    assign id_instr  = instr_q[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_p0    <= RESET_PC;
            vld_p1         <= 1'b0;
            inflight_pc_p1 <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc_p0 <= redirect_pc & ~32'h3;
            vld_p1      <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            // p1 -> FIFO: memory data returns for the request issued last edge
            if (push) begin
                pc_q[wr_ptr]    <= inflight_pc_p1;
                instr_q[wr_ptr] <= imem_instr;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            // p0 -> p1: request presented to memory
            if (issue) begin
                vld_p1         <= 1'b1;
                inflight_pc_p1 <= fetch_pc_p0;
                fetch_pc_p0    <= fetch_pc_p0 + 32'd4;
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push)
                perf_fetched <= perf_fetched + 32'd1;
            if (id_valid && !id_ready)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch front-end of the IF stage. Owns the PC, drives the address of the synchronous instruction memory (1-cycle registered read, word-indexed by addr[31:2]), and queues returned instructions with their PCs in a small prefetch FIFO. The FIFO feeds decode through a valid/ready handshake. Taken branches and jumps from EX redirect the PC and flush all younger fetched state.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; must be word-aligned.
- FIFO_DEPTH, 2, prefetch queue entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  fetch address to instruction memory; registered.
- imem_instr  in  32  memory read data; valid the cycle after imem_addr was sampled.
- redirect_valid  in  1  EX requests PC change this cycle.
- redirect_pc  in  32  new PC; bits [1:0] ignored and forced to 0.
- id_valid  out  1  FIFO head holds an instruction.
- id_ready  in  1  decode accepts head this cycle.
- id_pc  out  32  PC of head instruction.
- id_instr  out  32  head instruction word.

## Operation
- State: fetch_pc (drives imem_addr), inflight_v/inflight_pc (request sampled by memory at the last edge), FIFO storage, count (0..FIFO_DEPTH).
- pop = id_valid && id_ready; push = inflight_v (imem_instr with inflight_pc written at tail).
- Issue when !redirect_valid && (count + inflight_v − pop) < FIFO_DEPTH. On issue: inflight_v←1, inflight_pc←fetch_pc, fetch_pc←fetch_pc+4 (32-bit, wraps 32'hFFFF_FFFC→0). Otherwise inflight_v←0, fetch_pc held.
- Space for every push is reserved at issue; FIFO never overflows, count never exceeds FIFO_DEPTH.
- Redirect (highest priority): count←0, pointers←0, inflight_v←0, fetch_pc←{redirect_pc[31:2],2'b00}; no issue, no push that cycle. A pop coinciding with redirect is a completed handshake; downstream squashes it.
- id_valid = (count≠0); id_pc/id_instr = head entry; head stays stable while id_valid && !id_ready.
- Reset: fetch_pc=imem_addr=RESET_PC, inflight_v=0, count=0, FIFO storage 0, so id_valid=0, id_pc=0, id_instr=0. Reset mid-operation discards in-flight and queued instructions.

## Timing
- After rst deasserts: edge 1 issues RESET_PC; edge 2 pushes it; id_valid high after edge 2.
- Steady state with id_ready=1: one instruction per cycle, consecutive PCs.
- Redirect sampled at edge R: target issued at R+1, id_valid with target after R+2 (two bubble cycles).
- id_ready low: issue continues until count + inflight fills FIFO_DEPTH, then imem_addr holds; on id_ready returning, issue resumes the same cycle.
- No combinational path from any input to imem_addr; id_* come directly from FIFO registers.

## Configuration
- IF_FETCH_PERF_EN defined: adds outputs perf_fetched (32, increments per push) and perf_stall (32, increments each cycle id_valid && !id_ready); both wrap modulo 2^32, cleared only by rst.
- Undefined: these ports and counters do not exist; all other behaviour identical.

## Test plan
- Reset release, id_ready=1, memory words 0..3 = 00400093, 00800113, 002081b3, 0 -> id_valid first high after edge 2; pc/instr sequence 0/00400093, 4/00800113, 8/002081b3, one per cycle.
- id_ready=0 for 5 cycles after first valid -> id_pc stays 0, imem_addr stops advancing, exactly FIFO_DEPTH entries held; resume -> PCs 0,4,8 with no skip or duplicate.
- Redirect to 32'h0000_0043 while FIFO full -> id_valid low for two cycles, next id_pc=32'h40; no old-path PC appears afterwards.
- Redirect with id_valid && id_ready same cycle -> handshake counted, FIFO flushed, next valid id_pc = redirect target.
- RESET_PC=32'hFFFF_FFF8, id_ready=1 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With IF_FETCH_PERF_EN: 10 fetches, 3 stall cycles -> perf_fetched≥10, perf_stall=3; assert rst mid-stream -> both 0, id_valid 0 immediately.
